// File: rtl/ysyx_22040237_wb_ctrl_pkg.sv
// ysyx_22040237_wb_ctrl_pkg: shared widths, register-file reset value and write-source tag for the write-back block
package ysyx_22040237_wb_ctrl_pkg;
  localparam int XLEN_DEF = 64;
  localparam int REG_AW = 5;
  localparam logic [63:0] REGS_INIT = 64'h0;
  typedef enum logic {SRC_ALU, SRC_FIFO} wb_src_e;
endpackage

// File: rtl/ysyx_22040237_sync_fifo.sv
// ysyx_22040237_sync_fifo: power-of-2 synchronous fifo; push/pop/din in, dout (head, combinational), full, empty, cnt out
module ysyx_22040237_sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign cnt = cnt_q;
  assign dout = mem_q[rp_q];
  always_ff @(posedge clk)
    if (do_push) mem_q[wp_q] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/ysyx_22040237_wb_ctrl.sv
// ysyx_22040237_wb_ctrl: write-back arbiter (ALU first, buffered long-latency results next) with pending-register hazard tracking; ports: iss_*, alu_*, ll_* in / ll_ready out, reg_wr_en/wr_addr/wr_data out, reg1/reg2_rd_addr in, raw/waw_hazard out, fifo_cnt out
module ysyx_22040237_wb_ctrl
  import ysyx_22040237_wb_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int XLEN = XLEN_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         iss_valid,
  input  logic [REG_AW-1:0]            iss_rd,
  input  logic                         alu_valid,
  input  logic [REG_AW-1:0]            alu_rd,
  input  logic [XLEN-1:0]              alu_data,
  input  logic                         ll_valid,
  output logic                         ll_ready,
  input  logic [REG_AW-1:0]            ll_rd,
  input  logic [XLEN-1:0]              ll_data,
  output logic                         reg_wr_en,
  output logic [REG_AW-1:0]            wr_addr,
  output logic [XLEN-1:0]              wr_data,
  input  logic [REG_AW-1:0]            reg1_rd_addr,
  input  logic [REG_AW-1:0]            reg2_rd_addr,
  output logic                         raw_hazard,
  output logic                         waw_hazard,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_cnt
);
  localparam int EW = REG_AW + XLEN;
  logic push, pop, full, empty, alu_win;
  logic [EW-1:0] head;
  logic [31:0] pend_q, pend_d;
  logic wr_en_q, wr_en_d;
  wb_src_e src_q, src_d;
  logic [REG_AW-1:0] addr_q, addr_d;
  logic [XLEN-1:0] data_q, data_d;
  ysyx_22040237_sync_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din({ll_rd, ll_data}),
    .dout(head), .full(full), .empty(empty), .cnt(fifo_cnt)
  );
  assign ll_ready = !full;
  assign reg_wr_en = wr_en_q;
  assign wr_addr = addr_q;
  assign wr_data = data_q;
  assign raw_hazard = (pend_q[reg1_rd_addr] && reg1_rd_addr != '0) || (pend_q[reg2_rd_addr] && reg2_rd_addr != '0);
  assign waw_hazard = iss_valid && iss_rd != '0 && pend_q[iss_rd];
  always_comb begin
    alu_win = alu_valid && alu_rd != '0;
    pop = !alu_win && !empty;
    push = ll_valid && !full && ll_rd != '0;
    wr_en_d = alu_win || pop;
    src_d = alu_win ? SRC_ALU : SRC_FIFO;
    addr_d = alu_win ? alu_rd : head[EW-1 -: REG_AW];
    data_d = alu_win ? alu_data : head[XLEN-1:0];
    pend_d = pend_q;
    // the clear lands only once the data has been on the write port, and an issue to the same register overrides it
    if (wr_en_q && src_q == SRC_FIFO) pend_d[addr_q] = 1'b0;
    if (iss_valid && iss_rd != '0) pend_d[iss_rd] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q <= 1'b0;
      src_q <= SRC_ALU;
      addr_q <= '0;
      data_q <= REGS_INIT[XLEN-1:0];
      pend_q <= '0;
    end else begin
      wr_en_q <= wr_en_d;
      pend_q <= pend_d;
      if (wr_en_d) begin
        src_q <= src_d;
        addr_q <= addr_d;
        data_q <= data_d;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_22040237_wb_ctrl.sv
// tb_ysyx_22040237_wb_ctrl: randomized scoreboard bench with a queue-based reference model of the write-back block
module tb_ysyx_22040237_wb_ctrl;
  import ysyx_22040237_wb_ctrl_pkg::*;
  localparam int D = 4;
  localparam int XL = 64;
  logic clk = 1'b0, rst = 1'b1;
  logic iss_valid = 1'b0, alu_valid = 1'b0, ll_valid = 1'b0;
  logic [4:0] iss_rd = '0, alu_rd = '0, ll_rd = '0, reg1_rd_addr = '0, reg2_rd_addr = '0;
  logic [XL-1:0] alu_data = '0, ll_data = '0;
  logic ll_ready, reg_wr_en, raw_hazard, waw_hazard;
  logic [4:0] wr_addr;
  logic [XL-1:0] wr_data;
  logic [$clog2(D):0] fifo_cnt;
  ysyx_22040237_wb_ctrl #(.FIFO_DEPTH(D), .XLEN(XL)) dut (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
    .reg_wr_en(reg_wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .reg1_rd_addr(reg1_rd_addr), .reg2_rd_addr(reg2_rd_addr),
    .raw_hazard(raw_hazard), .waw_hazard(waw_hazard), .fifo_cnt(fifo_cnt)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int errs = 0, checks = 0;
  logic mon_on = 1'b0;
  typedef struct {int c; logic [4:0] a; logic [XL-1:0] d;} wr_t;
  typedef struct {logic [4:0] rd; logic [XL-1:0] d;} ll_t;
  wr_t exp_q[$];
  ll_t src_q[$], m_fifo[$];
  logic [31:0] m_pend = '0;
  logic m_fwr = 1'b0;
  logic [4:0] m_fwr_a = '0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  always @(negedge clk) begin
    wr_t w;
    if (mon_on) begin
      if (reg_wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL spurious_write: addr %0d data %h with no write expected (cycle %0d)", wr_addr, wr_data, cyc);
        end else begin
          w = exp_q.pop_front();
          chk("wr_cycle", 64'(cyc), 64'(w.c));
          chk("wr_addr", 64'(wr_addr), 64'(w.a));
          chk("wr_data", wr_data, w.d);
        end
      end else if (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
        w = exp_q.pop_front();
        checks++;
        errs++;
        $display("FAIL missing_write: reg_wr_en 0, expected addr %0d data %h (cycle %0d)", w.a, w.d, cyc);
      end
    end
  end
  task automatic step(input logic av, input logic [4:0] ard, input logic [XL-1:0] ad,
                      input logic iv, input logic [4:0] ird,
                      input logic [4:0] r1, input logic [4:0] r2, input logic go);
    ll_t h, l;
    logic awin, pop, acc, rdy;
    logic [31:0] np;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    iss_valid = iv; iss_rd = ird;
    reg1_rd_addr = r1; reg2_rd_addr = r2;
    ll_valid = go && src_q.size() > 0;
    ll_rd = ll_valid ? src_q[0].rd : 5'd0;
    ll_data = ll_valid ? src_q[0].d : '0;
    #1;
    rdy = m_fifo.size() < D;
    chk("ll_ready", 64'(ll_ready), 64'(rdy));
    chk("fifo_cnt", 64'(fifo_cnt), 64'(m_fifo.size()));
    chk("raw_hazard", 64'(raw_hazard), 64'((m_pend[r1] && r1 != 0) || (m_pend[r2] && r2 != 0)));
    chk("waw_hazard", 64'(waw_hazard), 64'(iv && ird != 0 && m_pend[ird]));
    awin = av && ard != 0;
    pop = !awin && m_fifo.size() > 0;
    acc = ll_valid && rdy;
    np = m_pend;
    if (m_fwr) np[m_fwr_a] = 1'b0;
    if (iv && ird != 0) np[ird] = 1'b1;
    if (awin) exp_q.push_back('{cyc + 1, ard, ad});
    else if (pop) begin
      h = m_fifo.pop_front();
      exp_q.push_back('{cyc + 1, h.rd, h.d});
    end
    m_fwr = pop;
    m_fwr_a = pop ? h.rd : 5'd0;
    if (acc) begin
      l = src_q.pop_front();
      if (l.rd != 0) m_fifo.push_back(l);
    end
    @(posedge clk);
    m_pend = np;
    #1;
  endtask
  task automatic idle(input int n, input logic [4:0] r1);
    repeat (n) step(1'b0, 5'd0, '0, 1'b0, 5'd0, r1, 5'd0, 1'b1);
  endtask
  task automatic do_reset(input int n);
    rst = 1'b1;
    alu_valid = 1'b0; iss_valid = 1'b0; ll_valid = 1'b0;
    reg1_rd_addr = '0; reg2_rd_addr = '0;
    repeat (n) @(posedge clk);
    m_fifo.delete();
    src_q.delete();
    m_pend = '0;
    m_fwr = 1'b0;
    #1;
    rst = 1'b0;
    chk("rst_reg_wr_en", 64'(reg_wr_en), 64'(0));
    chk("rst_wr_addr", 64'(wr_addr), 64'(0));
    chk("rst_wr_data", wr_data, REGS_INIT);
    chk("rst_fifo_cnt", 64'(fifo_cnt), 64'(0));
    chk("rst_ll_ready", 64'(ll_ready), 64'(1));
  endtask
  initial begin
    do_reset(2);
    mon_on = 1'b1;
    step(1'b1, 5'd5, 64'h11, 1'b0, 5'd0, 5'd5, 5'd0, 1'b1);
    idle(2, 5'd5);
    step(1'b0, 5'd0, '0, 1'b1, 5'd7, 5'd0, 5'd0, 1'b1);
    idle(1, 5'd7);
    src_q.push_back('{5'd7, 64'hAB});
    idle(4, 5'd7);
    src_q.push_back('{5'd10, 64'hA0});
    src_q.push_back('{5'd11, 64'hB0});
    for (int i = 0; i < 3; i++) step(1'b1, 5'(3 + i), 64'(100 + i), 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    idle(4, 5'd0);
    for (int i = 0; i < 5; i++) src_q.push_back('{5'(20 + i), 64'(32'hC000 + i)});
    for (int i = 0; i < 7; i++) step(1'b1, 5'(1 + i), 64'(200 + i), 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    idle(9, 5'd0);
    src_q.push_back('{5'd0, 64'h55});
    step(1'b1, 5'd0, 64'h66, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    idle(3, 5'd0);
    step(1'b0, 5'd0, '0, 1'b1, 5'd9, 5'd0, 5'd0, 1'b1);
    for (int i = 0; i < 3; i++) src_q.push_back('{5'(12 + i), 64'(32'hD000 + i)});
    for (int i = 0; i < 4; i++) step(1'b1, 5'(15 + i), 64'(300 + i), 1'b0, 5'd0, 5'd9, 5'd0, 1'b1);
    do_reset(1);
    idle(3, 5'd9);
    step(1'b0, 5'd0, '0, 1'b1, 5'd9, 5'd0, 5'd0, 1'b1);
    src_q.push_back('{5'd9, 64'h99});
    idle(2, 5'd9);
    step(1'b0, 5'd0, '0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1);
    idle(3, 5'd9);
    repeat (400) begin
      if ($urandom_range(2) == 0 && src_q.size() < 3)
        src_q.push_back('{5'($urandom_range(31)), {$urandom(), $urandom()}});
      step(1'($urandom_range(1)), 5'($urandom_range(31)), {$urandom(), $urandom()},
           1'($urandom_range(3) == 0), 5'($urandom_range(31)),
           5'($urandom_range(31)), 5'($urandom_range(31)), 1'($urandom_range(3) != 0));
    end
    for (int i = 0; i < 40 && (src_q.size() > 0 || m_fifo.size() > 0); i++) idle(1, 5'd0);
    idle(2, 5'd0);
    chk("drained_src", 64'(src_q.size() + m_fifo.size()), 64'(0));
    chk("drained_writes", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
